// File: rtl/edge_lane_detector.sv
// Lane edge-count detector: tracks pixel x/y, counts edge pixels per lane window and
// publishes a thresholded per-lane hit mask each frame. Macro EDGE_LANE_COUNTS_EN adds Counts.
module edge_lane_detector #(
   parameter int NUM_LANES  = 5,
   parameter int LANE_X0    = 100,
   parameter int LANE_PITCH = 60,
   parameter int LANE_WIDTH = 20,
   parameter int ROW_TOP    = 400,
   parameter int ROW_BOTTOM = 430,
   parameter int HIT_MIN    = 16,
   parameter int CNT_W      = 12
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 HSync,
   input  logic                 VDE,
   input  logic                 EdgeIn,
   input  logic                 HitAck,
   output logic [NUM_LANES-1:0] Hit,
   output logic                 HitValid,
   output logic                 Overrun
`ifdef EDGE_LANE_COUNTS_EN
   ,
   output logic [NUM_LANES*CNT_W-1:0] Counts
`endif
);

   localparam int XW = 16;
   localparam int YW = 11;
   localparam logic [XW-1:0]    X_MAX   = '1;
   localparam logic [YW-1:0]    Y_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [XW-1:0]    x;
   logic [YW-1:0]    y;
   logic             hs_q;
   logic             vde_q;
   logic             line_act;
   logic             armed;
   logic [CNT_W-1:0] cnt [NUM_LANES];

   logic                       hs_rise;
   logic                       vde_fall;
   logic                       frame_end;
   logic                       publish;
   logic                       ack_ok;
   logic                       row_in;
   logic                       pix_edge;
   logic [NUM_LANES-1:0]       in_win;
   logic [NUM_LANES-1:0]       hit_next;
   logic [NUM_LANES*CNT_W-1:0] counts_next;

   function automatic logic [31:0] lane_lo(input int unsigned lane);
      return 32'(LANE_X0) + lane * 32'(LANE_PITCH);
   endfunction

   always_comb begin
      hs_rise     = HSync & ~hs_q;
      vde_fall    = vde_q & ~VDE;
      // A frame ends on a sync edge that closes a line with no active video.
      frame_end   = hs_rise & ~line_act & (y != '0);
      publish     = frame_end & armed;
      ack_ok      = HitValid & HitAck;
      row_in      = (32'(y) >= 32'(ROW_TOP)) && (32'(y) <= 32'(ROW_BOTTOM));
      pix_edge    = VDE & EdgeIn & row_in;
      in_win      = '0;
      hit_next    = '0;
      counts_next = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         in_win[i]   = (32'(x) >= lane_lo(i)) &&
                       (32'(x) <= lane_lo(i) + 32'(LANE_WIDTH) - 32'd1);
         hit_next[i] = (32'(cnt[i]) >= 32'(HIT_MIN));
         counts_next[i*CNT_W +: CNT_W] = cnt[i];
      end
   end

   // x is held at zero whenever VDE is low, so the first active pixel of a line is x=0.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hs_q     <= 1'b0;
         vde_q    <= 1'b0;
         line_act <= 1'b0;
         x        <= '0;
         y        <= '0;
         armed    <= 1'b0;
      end else begin
         hs_q  <= HSync;
         vde_q <= VDE;
         if (hs_rise)
            line_act <= VDE;
         else if (VDE)
            line_act <= 1'b1;
         if (VDE) begin
            if (x != X_MAX)
               x <= x + 1'b1;
         end else begin
            x <= '0;
         end
         if (frame_end)
            y <= '0;
         else if (vde_fall && (y != Y_MAX))
            y <= y + 1'b1;
         if (frame_end)
            armed <= 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int unsigned i = 0; i < NUM_LANES; i++)
            cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (frame_end)
               cnt[i] <= '0;
            else if (pix_edge && in_win[i] && (cnt[i] != CNT_MAX))
               cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   // The first frame end after reset only arms publication; its counts may be partial.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         Hit      <= '0;
         HitValid <= 1'b0;
         Overrun  <= 1'b0;
      end else if (publish) begin
         Hit      <= hit_next;
         HitValid <= 1'b1;
         if (HitValid && !HitAck)
            Overrun <= 1'b1;
      end else if (ack_ok) begin
         HitValid <= 1'b0;
         Overrun  <= 1'b0;
      end
   end

`ifdef EDGE_LANE_COUNTS_EN
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         Counts <= '0;
      else if (publish)
         Counts <= counts_next;
   end
`else
   logic unused_counts;
   assign unused_counts = ^counts_next;
`endif

endmodule
